// File: rtl/max7219_frame_sequencer.sv
// MAX7219 frame sequencer.
// Issues the MAX7219 init sequence after reset, then writes one HH:MM:SS frame (digits 1..6)
// per refresh request, one register write at a time over the driver's stb/busy handshake.
// Ports:
//   i_clk, i_reset_n       clock, asynchronous active-low reset
//   i_refresh              1-cycle frame request (merged into a 1-deep pending flag when busy)
//   i_hours/minutes/secs   BCD time {tens,ones}
//   i_colon                set DP on the digits at addr 3 and 5
//   i_blank_leading        send hours-tens of 0 as code-B blank (0x0F)
//   i_intensity            brightness for reg 0xA
//   o_stb/o_addr/o_data    write request to the serial driver
//   i_busy                 driver busy
//   o_init_done            init sequence finished
//   o_frame_busy           init or frame in progress
//   o_timeout              sticky: a request was abandoned for lack of i_busy
module max7219_frame_sequencer #(
   parameter logic [2:0]  SCAN_LIMIT  = 3'd5,
   parameter logic [7:0]  DECODE_MODE = 8'hFF,
   parameter int unsigned REQ_TIMEOUT = 64
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic       i_refresh,
   input  logic [7:0] i_hours,
   input  logic [7:0] i_minutes,
   input  logic [7:0] i_seconds,
   input  logic       i_colon,
   input  logic       i_blank_leading,
   input  logic [3:0] i_intensity,
   output logic       o_stb,
   output logic [3:0] o_addr,
   output logic [7:0] o_data,
   input  logic       i_busy,
   output logic       o_init_done,
   output logic       o_frame_busy,
   output logic       o_timeout
);

   localparam int unsigned CntW = $clog2(REQ_TIMEOUT + 1);
   localparam logic [CntW-1:0] CntMax = CntW'(REQ_TIMEOUT - 1);

   typedef enum logic [1:0] {StIdle, StLoad, StReq, StDrain} state_e;

   state_e          state_q, state_d;
   logic [2:0]      idx_q;
   logic            in_init_q;
   logic            pending_q;
   logic [3:0]      last_int_q;
   logic [7:0]      hr_q, min_q, sec_q;
   logic            colon_q, blank_q;
   logic [3:0]      int_q;
   logic [3:0]      addr_q;
   logic [7:0]      data_q;
   logic [CntW-1:0] cnt_q;
   logic            timeout_q, init_done_q, frame_busy_q;

   logic       req_abort, entry_done, list_end, start_frame;
   logic [2:0] last_idx;
   logic [3:0] entry_addr;
   logic [7:0] entry_data;

   // An entry completes either normally (driver went idle after accepting) or by abandonment.
   assign req_abort   = (state_q == StReq) && !i_busy && (cnt_q == CntMax);
   assign entry_done  = ((state_q == StDrain) && !i_busy) || req_abort;
   assign last_idx    = in_init_q ? 3'd4 : 3'd6;
   assign list_end    = entry_done && (idx_q == last_idx);
   // A new frame begins from IDLE, or back-to-back at list end when a request is waiting.
   assign start_frame = ((state_q == StIdle) || list_end) && (i_refresh || pending_q);

   // Current list entry; frame index 0 is the optional intensity write.
   always_comb begin
      entry_addr = 4'h0;
      entry_data = 8'h00;
      if (in_init_q) begin
         case (idx_q)
            3'd0:    begin entry_addr = 4'h9; entry_data = DECODE_MODE;            end
            3'd1:    begin entry_addr = 4'hA; entry_data = {4'h0, i_intensity};    end
            3'd2:    begin entry_addr = 4'hB; entry_data = {5'b0, SCAN_LIMIT};     end
            3'd3:    begin entry_addr = 4'hC; entry_data = 8'h01;                  end
            default: begin entry_addr = 4'hF; entry_data = 8'h00;                  end
         endcase
      end else begin
         case (idx_q)
            3'd0:    begin entry_addr = 4'hA; entry_data = {4'h0, int_q};             end
            3'd1:    begin entry_addr = 4'h1; entry_data = {4'h0, sec_q[3:0]};        end
            3'd2:    begin entry_addr = 4'h2; entry_data = {4'h0, sec_q[7:4]};        end
            3'd3:    begin entry_addr = 4'h3; entry_data = {colon_q, 3'b0, min_q[3:0]}; end
            3'd4:    begin entry_addr = 4'h4; entry_data = {4'h0, min_q[7:4]};        end
            3'd5:    begin entry_addr = 4'h5; entry_data = {colon_q, 3'b0, hr_q[3:0]};  end
            default: begin
               entry_addr = 4'h6;
               entry_data = (blank_q && (hr_q[7:4] == 4'h0)) ? 8'h0F : {4'h0, hr_q[7:4]};
            end
         endcase
      end
   end

   // State register
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) state_q <= StLoad;
      else            state_q <= state_d;
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         StIdle:  if (start_frame) state_d = StLoad;
         StLoad:  state_d = StReq;
         StReq: begin
            if (i_busy)         state_d = StDrain;
            else if (req_abort) state_d = (list_end && !start_frame) ? StIdle : StLoad;
         end
         StDrain: if (!i_busy) state_d = (list_end && !start_frame) ? StIdle : StLoad;
         default: state_d = StIdle;
      endcase
   end

   // Outputs
   always_comb begin
      o_stb        = (state_q == StReq);
      o_addr       = addr_q;
      o_data       = data_q;
      o_init_done  = init_done_q;
      o_frame_busy = frame_busy_q;
      o_timeout    = timeout_q;
   end

   // Datapath
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         idx_q        <= 3'd0;
         in_init_q    <= 1'b1;
         pending_q    <= 1'b0;
         last_int_q   <= 4'h0;
         hr_q         <= 8'h00;
         min_q        <= 8'h00;
         sec_q        <= 8'h00;
         colon_q      <= 1'b0;
         blank_q      <= 1'b0;
         int_q        <= 4'h0;
         addr_q       <= 4'h0;
         data_q       <= 8'h00;
         cnt_q        <= '0;
         timeout_q    <= 1'b0;
         init_done_q  <= 1'b0;
         frame_busy_q <= 1'b0;
      end else begin
         pending_q <= start_frame ? 1'b0 : (pending_q | i_refresh);
         if (list_end && in_init_q) begin
            init_done_q <= 1'b1;
            in_init_q   <= 1'b0;
         end
         if (start_frame) begin
            hr_q      <= i_hours;
            min_q     <= i_minutes;
            sec_q     <= i_seconds;
            colon_q   <= i_colon;
            blank_q   <= i_blank_leading;
            int_q     <= i_intensity;
            in_init_q <= 1'b0;
            // Skip the intensity write when the display already holds this value.
            idx_q     <= (i_intensity != last_int_q) ? 3'd0 : 3'd1;
         end else if (entry_done && !list_end) begin
            idx_q <= idx_q + 3'd1;
         end
         if (state_q == StLoad) begin
            addr_q <= entry_addr;
            data_q <= entry_data;
         end
         cnt_q <= (state_q == StReq) ? cnt_q + CntW'(1) : '0;
         if (req_abort) timeout_q <= 1'b1;
         if ((state_q == StDrain) && !i_busy && (addr_q == 4'hA)) last_int_q <= data_q[3:0];
         frame_busy_q <= (state_d != StIdle);
      end
   end

endmodule

// File: tb/tb_max7219_frame_sequencer.sv
module tb_max7219_frame_sequencer;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       refresh = 1'b0;
   logic [7:0] hours = 8'h00, minutes = 8'h00, seconds = 8'h00;
   logic       colon = 1'b0, blank = 1'b0;
   logic [3:0] intensity = 4'h3;
   logic       stb;
   logic [3:0] addr;
   logic [7:0] data;
   logic       busy = 1'b0;
   logic       init_done, frame_busy, timeout;

   int ntests = 0;
   int nfail  = 0;
   logic drv_en = 1'b1;
   int busy_cnt = 0;
   logic [11:0] wr_q[$];

   always #5 clk = ~clk;

   max7219_frame_sequencer dut (
      .i_clk           (clk),
      .i_reset_n       (rst_n),
      .i_refresh       (refresh),
      .i_hours         (hours),
      .i_minutes       (minutes),
      .i_seconds       (seconds),
      .i_colon         (colon),
      .i_blank_leading (blank),
      .i_intensity     (intensity),
      .o_stb           (stb),
      .o_addr          (addr),
      .o_data          (data),
      .i_busy          (busy),
      .o_init_done     (init_done),
      .o_frame_busy    (frame_busy),
      .o_timeout       (timeout)
   );

   // Driver model: accept a request, stay busy for three cycles.
   always @(posedge clk) begin
      #1;
      if (!drv_en) begin
         busy = 1'b0;
         busy_cnt = 0;
      end else if (busy_cnt > 0) begin
         busy_cnt--;
         if (busy_cnt == 0) busy = 1'b0;
      end else if (stb) begin
         busy = 1'b1;
         busy_cnt = 3;
      end
   end

   // Record each accepted write once (stb and busy overlap for exactly one cycle).
   always @(negedge clk) if (stb && busy) wr_q.push_back({addr, data});

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ntests++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic wait_writes(input string tag, input int n, input int budget);
      for (int i = 0; i < budget && wr_q.size() < n; i++) @(negedge clk);
      check(tag, wr_q.size(), n);
   endtask

   task automatic wait_idle(input string tag, input int budget);
      for (int i = 0; i < budget && frame_busy; i++) @(negedge clk);
      check(tag, {31'b0, frame_busy}, 32'd0);
   endtask

   task automatic pulse_refresh();
      @(negedge clk) refresh = 1'b1;
      @(negedge clk) refresh = 1'b0;
   endtask

   function automatic logic [11:0] wr(input int i);
      if (i < wr_q.size()) return wr_q[i];
      return 12'hXXX;
   endfunction

   initial begin
      int run;
      // Reset state
      repeat (2) @(negedge clk);
      check("rst_stb", {31'b0, stb}, 0);
      check("rst_addr_data", {20'b0, addr, data}, 0);
      check("rst_flags", {29'b0, init_done, frame_busy, timeout}, 0);
      rst_n = 1'b1;
      #1 check("stb_before_first_edge", {31'b0, stb}, 0);
      @(posedge clk); #1;
      check("first_req", {19'b0, stb, addr, data}, {19'b0, 1'b1, 4'h9, 8'hFF});

      // Init sequence
      wait_writes("init_count", 5, 200);
      wait_idle("init_idle", 50);
      check("init_0", wr(0), 12'h9FF);
      check("init_1", wr(1), 12'hA03);
      check("init_2", wr(2), 12'hB05);
      check("init_3", wr(3), 12'hC01);
      check("init_4", wr(4), 12'hF00);
      check("init_done", {31'b0, init_done}, 1);
      check("no_timeout", {31'b0, timeout}, 0);

      // 12:34:56 with colon; inputs scrambled right after the snapshot edge
      wr_q.delete();
      hours = 8'h12; minutes = 8'h34; seconds = 8'h56; colon = 1'b1; blank = 1'b0;
      pulse_refresh();
      hours = 8'h99; minutes = 8'h99; seconds = 8'h99; colon = 1'b0; blank = 1'b1;
      intensity = 4'hF;
      wait_idle("f1_idle", 200);
      check("f1_count", wr_q.size(), 6);
      check("f1_d1", wr(0), 12'h106);
      check("f1_d2", wr(1), 12'h205);
      check("f1_d3", wr(2), 12'h384);
      check("f1_d4", wr(3), 12'h403);
      check("f1_d5", wr(4), 12'h582);
      check("f1_d6", wr(5), 12'h601);

      // 08:00:00 with leading blank
      wr_q.delete();
      intensity = 4'h3;
      hours = 8'h08; minutes = 8'h00; seconds = 8'h00; colon = 1'b0; blank = 1'b1;
      pulse_refresh();
      wait_idle("f2_idle", 200);
      check("f2_count", wr_q.size(), 6);
      check("f2_d5", wr(4), 12'h508);
      check("f2_blank", wr(5), 12'h60F);

      // Intensity change 3 -> 9
      wr_q.delete();
      intensity = 4'h9; blank = 1'b0;
      pulse_refresh();
      wait_idle("f3_idle", 200);
      check("f3_count", wr_q.size(), 7);
      check("f3_int", wr(0), 12'hA09);
      check("f3_d1", wr(1), 12'h100);
      check("f3_d6", wr(6), 12'h600);

      // Two refresh pulses mid-frame -> one extra frame with fresh values
      wr_q.delete();
      hours = 8'h01; minutes = 8'h02; seconds = 8'h03;
      pulse_refresh();
      wait_writes("pend_first", 1, 50);
      hours = 8'h04; minutes = 8'h05; seconds = 8'h06;
      pulse_refresh();
      @(negedge clk);
      pulse_refresh();
      wait_idle("pend_idle", 400);
      check("pend_count", wr_q.size(), 12);
      check("pend_a_d1", wr(0), 12'h103);
      check("pend_a_d5", wr(4), 12'h501);
      check("pend_b_d1", wr(6), 12'h106);
      check("pend_b_d3", wr(8), 12'h305);
      check("pend_b_d5", wr(10), 12'h504);

      // Driver never answers: each request abandoned after the timeout
      wr_q.delete();
      drv_en = 1'b0;
      pulse_refresh();
      run = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (stb) run++;
         else if (run > 0) break;
      end
      check("stb_run_len", run, 64);
      check("timeout_set", {31'b0, timeout}, 1);
      wait_idle("to_idle", 1000);
      check("to_no_writes", wr_q.size(), 0);

      // Async reset in the middle of a request
      pulse_refresh();
      for (int i = 0; i < 20 && !stb; i++) @(negedge clk);
      check("stb_before_reset", {31'b0, stb}, 1);
      @(posedge clk); #3;
      rst_n = 1'b0;
      #1 check("async_rst", {29'b0, stb, init_done, timeout}, 0);
      repeat (2) @(negedge clk);
      drv_en = 1'b1;
      wr_q.delete();
      rst_n = 1'b1;
      wait_writes("reinit_count", 5, 200);
      check("reinit_0", wr(0), 12'h9FF);
      check("reinit_1", wr(1), 12'hA09);
      check("reinit_4", wr(4), 12'hF00);

      $display("[TB] %0d tests run, %0d failed", ntests, nfail);
      $finish;
   end

endmodule
